sramlike_arbiter: RTL
=====================

Name: sramlike_arbiter

Overview:
- Shares one downstream sram-like port between the instruction-side and data-side sram-like requesters. These are the outputs of the inst/data sram-to-sramlike bridges.
- Sits between the two bridges and the single sram-like-to-AXI interface.
- Allows one outstanding transaction at a time.
- Data side has priority; a starvation counter guarantees instruction fetch progress.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants allowed while inst_req is pending before inst is forced to win.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  inst requester request
- inst_wr  in  1  inst write flag
- inst_size  in  2  inst transfer size (0=byte, 1=half, 2=word)
- inst_addr  in  32  inst address
- inst_wdata  in  32  inst write data
- inst_rdata  out  32  read data returned to inst
- inst_addr_ok  out  1  inst address handshake
- inst_data_ok  out  1  inst data handshake
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data requester, same meanings as the inst_* inputs
- data_rdata, data_addr_ok, data_data_ok  out  32/1/1  data responses, same meanings as the inst_* outputs
- m_req  out  1  downstream request
- m_wr  out  1  downstream write flag
- m_size  out  2  downstream transfer size
- m_addr  out  32  downstream address
- m_wdata  out  32  downstream write data
- m_rdata  in  32  downstream read data
- m_addr_ok  in  1  downstream address handshake
- m_data_ok  in  1  downstream data handshake
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: on rst assertion, immediately (asynchronously) state=IDLE, grant=NONE, starvation counter=0, latched request fields=0.
  - All registered outputs and all *_ok outputs read 0; m_req=0 and busy=0.
  - A transaction in flight at reset is abandoned; a later m_data_ok for it arrives in IDLE and is ignored.
- States: IDLE, ADDR, DATA. Register grant ∈ {NONE, INST, DATA}.
- IDLE:
  - Selection: if data_req and inst_req are both high and the counter equals STARVE_LIMIT, pick INST. Otherwise pick DATA if data_req, else INST if inst_req.
  - On a pick: latch the winner's wr/size/addr/wdata and go to ADDR next cycle. This is one cycle of arbitration latency; no *_addr_ok is given in IDLE.
  - Counter update: increments when DATA wins while inst_req is high; clears when INST wins or inst_req is low. It saturates at STARVE_LIMIT.
  - m_addr_ok and m_data_ok seen in IDLE are ignored.
- ADDR:
  - m_req=1, driven from the latched fields only. Fields stay stable even if the requester changes its inputs.
  - When m_addr_ok=1: pulse the granted requester's *_addr_ok in the same cycle (combinational pass-through).
    - If m_data_ok is also 1 that cycle, the transaction completes: pulse *_data_ok and go to IDLE.
    - Otherwise go to DATA.
  - m_data_ok without m_addr_ok in ADDR is ignored (stale).
- DATA:
  - m_req=0.
  - When m_data_ok=1: pulse the granted *_data_ok in the same cycle, set grant=NONE, go to IDLE.
- Read data: inst_rdata and data_rdata are both combinational copies of m_rdata. They are meaningful only while the matching *_data_ok is high. With m_rdata at 0 during reset, they read 0.
- The non-granted requester never sees addr_ok or data_ok.
- Simultaneous events:
  - A requester dropping req while in ADDR does not cancel the transaction; requesters are required to hold req until addr_ok.
  - A new request arriving during ADDR/DATA waits and is evaluated in IDLE.
- Back-to-back: minimum of 3 cycles per transaction when addr_ok and data_ok arrive on the first possible cycles. This is 2 cycles if addr_ok and data_ok arrive together.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/ADDR/DATA) and the grant enum (NONE/INST/DATA);
  - the size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
- One natural sub-module: sramlike_prio_sel. It is the combinational priority select plus the starvation counter, outputting the winner and the counter-next value.
- The FSM, field latches and response demux stay in the top.

Test Plan:
- Inst only: inst_req=1 with addr 0xBFC00000; downstream gives addr_ok at cycle 2 and data_ok at cycle 4 with rdata 0x3C080001. Required: m_addr=0xBFC00000, inst_addr_ok in cycle 2, inst_data_ok and inst_rdata=0x3C080001 in cycle 4, data_* ok outputs stay 0.
- Contention: inst_req and data_req both held continuously, STARVE_LIMIT=4. Required grant order: D,D,D,D,I,D,D,D,D,I.
- Same-cycle completion: in ADDR, m_addr_ok=1 and m_data_ok=1 together. Required: data_addr_ok and data_data_ok pulse in the same cycle, and state returns to IDLE next cycle.
- Stale data_ok: m_data_ok=1 in IDLE, and again in ADDR without addr_ok. Required: no *_data_ok pulses and no state change.
- Field stability: data write to addr 0x80001000, wdata 0xDEADBEEF, size 2; the requester changes data_addr to 0 while in ADDR. Required: m_addr stays 0x80001000 and m_wr=1 until m_addr_ok.
- Async reset in DATA: assert rst mid-cycle. Required: busy, m_req and all *_ok outputs go 0 immediately. After release, a late m_data_ok produces no response.

Source files
------------

// File: rtl/sramlike_arbiter_pkg.sv
// Shared types for the sram-like arbiter: FSM states, grant owner, size codes
// and the latched request fields.
package sramlike_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } grant_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_fields_t;

endpackage

// File: rtl/sramlike_prio_sel.sv
// Data-first priority select with a saturating starvation counter that hands
// the port to inst once data has won STARVE_LIMIT times in a row over it.
module sramlike_prio_sel
    import sramlike_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             arb_en,
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] cnt_q,
    output grant_e           win,
    output logic [CNT_W-1:0] cnt_d
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    always_comb begin
        win   = GNT_NONE;
        cnt_d = cnt_q;
        if (arb_en) begin
            if (data_req && inst_req && (cnt_q == LIMIT)) begin
                win = GNT_INST;
            end else if (data_req) begin
                win = GNT_DATA;
            end else if (inst_req) begin
                win = GNT_INST;
            end

            // Count only data wins that actually made inst wait.
            if ((win == GNT_DATA) && inst_req) begin
                cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

endmodule

// File: rtl/sramlike_arbiter.sv
// Two-to-one sram-like arbiter: one outstanding transaction, request fields
// latched at grant time, responses routed back to the granted side only.
module sramlike_arbiter
    import sramlike_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,

    output logic        busy
);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_fields_t       fields_q, fields_d;
    grant_e            win;
    logic              addr_hs;
    logic              data_hs;

    sramlike_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio_sel (
        .arb_en   (state_q == ST_IDLE),
        .inst_req (inst_req),
        .data_req (data_req),
        .cnt_q    (cnt_q),
        .win      (win),
        .cnt_d    (cnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= GNT_NONE;
            cnt_q    <= '0;
            fields_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            fields_q <= fields_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        fields_d = fields_q;
        case (state_q)
            ST_IDLE: begin
                if (win != GNT_NONE) begin
                    grant_d = win;
                    state_d = ST_ADDR;
                    if (win == GNT_DATA) begin
                        fields_d = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
                    end else begin
                        fields_d = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
                    end
                end
            end
            ST_ADDR: begin
                // A data_ok without addr_ok here belongs to an abandoned transaction.
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        state_d = ST_IDLE;
                        grant_d = GNT_NONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_comb begin
        addr_hs = (state_q == ST_ADDR) && m_addr_ok;
        data_hs = (addr_hs && m_data_ok) || ((state_q == ST_DATA) && m_data_ok);

        inst_addr_ok = addr_hs && (grant_q == GNT_INST);
        inst_data_ok = data_hs && (grant_q == GNT_INST);
        data_addr_ok = addr_hs && (grant_q == GNT_DATA);
        data_data_ok = data_hs && (grant_q == GNT_DATA);

        inst_rdata = m_rdata;
        data_rdata = m_rdata;

        m_req   = (state_q == ST_ADDR);
        m_wr    = fields_q.wr;
        m_size  = fields_q.size;
        m_addr  = fields_q.addr;
        m_wdata = fields_q.wdata;
        busy    = (state_q != ST_IDLE);
    end

endmodule
